// File: rtl/multi_events_to_apb.sv
// Per-channel event counters drained to an APB completer as write transfers,
// one channel per transfer, channels served in round-robin order.
module multi_events_to_apb #(
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hE000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [31:0]           apb_paddr_o,
  output logic [31:0]           apb_pwdata_o,
  input  logic                  apb_pready_i,
  input  logic                  apb_pslverr_i,
  output logic                  apb_err_o,
  output logic [NUM_EVENTS-1:0] overflow_o,
  output logic [1:0]            dbg_state_o
);
  // APB handshake: psel/pwrite rise in SETUP, penable joins in ACCESS; the
  // transfer completes on the ACCESS cycle with pready=1, and pslverr is
  // sampled on that cycle only.
  localparam int unsigned IW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NUM_EVENTS];
  logic [CNT_W-1:0]      cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [CNT_W-1:0]      pwdata_q, pwdata_d;
  logic                  err_q, err_d;

  logic [NUM_EVENTS-1:0] pending;
  logic                  found;
  logic [IW-1:0]         pick;
  logic [IW:0]           rr_sum;
  logic [CNT_W:0]        retry_sum;

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    pending = '0;
    found   = 1'b0;
    pick    = '0;
    rr_sum  = '0;
    for (int k = 0; k < int'(NUM_EVENTS); k++) begin
      pending[k] = (cnt_q[k] != '0) || event_i[k];
    end
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NUM_EVENTS)) rr_sum = rr_sum - (IW+1)'(NUM_EVENTS);
      if (!found && pending[rr_sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = rr_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    err_d     = 1'b0;
    ovf_d     = ovf_q;
    retry_sum = '0;
    for (int k = 0; k < int'(NUM_EVENTS); k++) begin
      cnt_d[k] = cnt_q[k];
      if (event_i[k]) begin
        if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
        else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = SETUP;
          gnt_d       = pick;
          ptr_d       = (pick == IW'(NUM_EVENTS - 1)) ? '0 : pick + IW'(1);
          paddr_d     = BASE_ADDR + 32'(pick) * ADDR_STRIDE;
          // cnt_d already holds the saturated count including this cycle's event.
          pwdata_d    = cnt_d[pick];
          cnt_d[pick] = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb_pready_i) begin
          state_d  = IDLE;
          paddr_d  = '0;
          pwdata_d = '0;
          if (apb_pslverr_i) begin
            err_d     = 1'b1;
            retry_sum = {1'b0, cnt_d[gnt_q]} + {1'b0, pwdata_q};
            if (retry_sum[CNT_W]) begin
              cnt_d[gnt_q] = CNT_MAX;
              ovf_d[gnt_q] = 1'b1;
            end else begin
              cnt_d[gnt_q] = retry_sum[CNT_W-1:0];
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        paddr_d  = '0;
        pwdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign apb_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable_o = (state_q == ACCESS);
  assign apb_pwrite_o  = apb_psel_o;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = {{(32-CNT_W){1'b0}}, pwdata_q};
  assign apb_err_o     = err_q;
  assign overflow_o    = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multi_events_to_apb.sv
// Bench for multi_events_to_apb: a default instance and a CNT_W=2 instance
// share stimulus; a channel-level model is checked every cycle.
module tb_multi_events_to_apb;
  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] ev      = '0;
  logic       pready  = 1'b1;
  logic       pslverr = 1'b0;

  logic        psel_a, pen_a, pwr_a, err_a;
  logic [31:0] paddr_a, pwdata_a;
  logic [3:0]  ovf_a;
  logic [1:0]  dbg_a;
  logic        psel_b, pen_b, pwr_b, err_b;
  logic [31:0] paddr_b, pwdata_b;
  logic [3:0]  ovf_b;
  logic [1:0]  dbg_b;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_sat_q[$];
  bit chk_sat = 1'b0;

  always #5 clk = ~clk;

  multi_events_to_apb u_dut (
    .clk(clk), .reset_n(reset_n), .event_i(ev),
    .apb_psel_o(psel_a), .apb_penable_o(pen_a), .apb_pwrite_o(pwr_a),
    .apb_paddr_o(paddr_a), .apb_pwdata_o(pwdata_a),
    .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .apb_err_o(err_a), .overflow_o(ovf_a), .dbg_state_o(dbg_a)
  );

  multi_events_to_apb #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .event_i(ev),
    .apb_psel_o(psel_b), .apb_penable_o(pen_b), .apb_pwrite_o(pwr_b),
    .apb_paddr_o(paddr_b), .apb_pwdata_o(pwdata_b),
    .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .apb_err_o(err_b), .overflow_o(ovf_b), .dbg_state_o(dbg_b)
  );

  // ---------------- behavioural model (index 0 = u_dut, 1 = u_sat) --------
  int         m_max [2] = '{255, 3};
  int         m_cnt [2][4];
  logic [3:0] m_ovf [2];
  int         m_phase [2];  // 0 no transfer, 1 first bus cycle, 2 waiting for pready
  int         m_gnt [2];
  int         m_next [2];
  int         m_val [2];
  bit         m_err [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      m_ovf[i] = '0; m_phase[i] = 0; m_gnt[i] = 0;
      m_next[i] = 0; m_val[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int c;
    int s;
    bit hit;
    m_err[i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) begin
        if (m_cnt[i][k] == m_max[i]) m_ovf[i][k] = 1'b1;
        else m_cnt[i][k] = m_cnt[i][k] + 1;
      end
    end
    if (m_phase[i] == 0) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
        c = (m_next[i] + j) % 4;
        if (!hit && m_cnt[i][c] != 0) begin
          hit = 1'b1;
          m_gnt[i] = c;
          m_val[i] = m_cnt[i][c];
          m_cnt[i][c] = 0;
          m_next[i] = (c + 1) % 4;
          m_phase[i] = 1;
        end
      end
    end else if (m_phase[i] == 1) begin
      m_phase[i] = 2;
    end else if (pready) begin
      m_phase[i] = 0;
      if (pslverr) begin
        m_err[i] = 1'b1;
        s = m_cnt[i][m_gnt[i]] + m_val[i];
        if (s > m_max[i]) begin
          s = m_max[i];
          m_ovf[i][m_gnt[i]] = 1'b1;
        end
        m_cnt[i][m_gnt[i]] = s;
      end
    end
  endtask

  function automatic logic [71:0] model_out(input int i);
    logic on;
    logic [31:0] a;
    logic [31:0] d;
    on = (m_phase[i] != 0);
    a  = on ? 32'hE000_0000 + 32'(m_gnt[i]) * 32'h0000_1000 : 32'h0;
    d  = on ? 32'(m_val[i]) : 32'h0;
    return {on, m_phase[i] == 2, on, m_err[i], a, d, m_ovf[i]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input int i, input logic [71:0] act, input logic [1:0] dbg);
    logic [71:0] exp;
    exp = model_out(i);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL outputs_%0d t=%0t: got %h expected %h (dbg_state %0d)", i, $time, act, exp, dbg);
    end
  endtask

  task automatic cmp_xfer(input string name, input logic [63:0] act, inout logic [63:0] q[$]);
    logic [63:0] exp;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected transfer %h expected none", name, act);
    end else begin
      exp = q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    cmp_out(0, {psel_a, pen_a, pwr_a, err_a, paddr_a, pwdata_a, ovf_a}, dbg_a);
    cmp_out(1, {psel_b, pen_b, pwr_b, err_b, paddr_b, pwdata_b, ovf_b}, dbg_b);
    if (pen_a && pready) cmp_xfer("xfer_dut", {paddr_a, pwdata_a}, exp_q);
    if (chk_sat && pen_b && pready) cmp_xfer("xfer_sat", {paddr_b, pwdata_b}, exp_sat_q);
  end

  // ---------------- drivers ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    ev = '0; pready = 1'b1; pslverr = 1'b0; reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    run(2);
    check("rst_psel", 32'(psel_a), 32'd0);
    check("rst_paddr", paddr_a, 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    do_reset();

    // single ch1 event: latency and address
    exp_q.push_back({32'hE000_1000, 32'd1});
    ev = 4'b0010; tick(); ev = '0;
    check("lat_psel", 32'(psel_a), 32'd1);
    check("lat_pen_early", 32'(pen_a), 32'd0);
    check("t1_addr", paddr_a, 32'hE000_1000);
    check("t1_data", pwdata_a, 32'd1);
    tick();
    check("lat_pen", 32'(pen_a), 32'd1);
    run(10);

    // all four channels at once: served 0,1,2,3
    do_reset();
    exp_q.push_back({32'hE000_0000, 32'd1});
    exp_q.push_back({32'hE000_1000, 32'd1});
    exp_q.push_back({32'hE000_2000, 32'd1});
    exp_q.push_back({32'hE000_3000, 32'd1});
    ev = 4'b1111; tick(); ev = '0;
    run(15);

    // ch2 held with a stalled completer: 1 sent, 6 accumulated
    do_reset();
    exp_q.push_back({32'hE000_2000, 32'd1});
    exp_q.push_back({32'hE000_2000, 32'd6});
    pready = 1'b0; ev = 4'b0100;
    run(2);
    repeat (5) begin
      tick();
      check("t3_pen", 32'(pen_a), 32'd1);
      check("t3_addr", paddr_a, 32'hE000_2000);
      check("t3_data", pwdata_a, 32'd1);
    end
    pready = 1'b1; ev = '0;
    run(15);

    // five ch0 events during a stall: narrow counter saturates at 3
    do_reset();
    chk_sat = 1'b1;
    exp_q.push_back({32'hE000_1000, 32'd1});
    exp_q.push_back({32'hE000_0000, 32'd5});
    exp_sat_q.push_back({32'hE000_1000, 32'd1});
    exp_sat_q.push_back({32'hE000_0000, 32'd3});
    pready = 1'b0; ev = 4'b0010; tick();
    ev = 4'b0001; run(5);
    ev = '0; pready = 1'b1;
    run(15);
    check("t4_ovf_sat", 32'(ovf_b), 32'd1);
    check("t4_ovf_dut", 32'(ovf_a), 32'd0);

    // errored transfer of 3 is retried with a same-cycle event added
    do_reset();
    exp_q.push_back({32'hE000_1000, 32'd1});
    exp_q.push_back({32'hE000_0000, 32'd3});
    exp_q.push_back({32'hE000_0000, 32'd4});
    exp_sat_q.push_back({32'hE000_1000, 32'd1});
    exp_sat_q.push_back({32'hE000_0000, 32'd3});
    exp_sat_q.push_back({32'hE000_0000, 32'd3});
    pready = 1'b0; ev = 4'b0010; tick();
    ev = 4'b0001; run(3);
    ev = '0; pready = 1'b1; tick();
    pslverr = 1'b1;
    run(2);
    check("t5_data", pwdata_a, 32'd3);
    ev = 4'b0001; tick();
    ev = '0; pslverr = 1'b0;
    check("t5_err_dut", 32'(err_a), 32'd1);
    check("t5_err_sat", 32'(err_b), 32'd1);
    tick();
    check("t5_err_clear", 32'(err_a), 32'd0);
    check("t5_retry_dut", pwdata_a, 32'd4);
    check("t5_retry_sat", pwdata_b, 32'd3);
    check("t5_ovf_sat", 32'(ovf_b), 32'd1);
    run(15);
    chk_sat = 1'b0;

    // reset in ACCESS aborts the transfer and discards pending counts
    do_reset();
    pready = 1'b0; ev = 4'b0011; tick();
    ev = '0; run(2);
    reset_n = 1'b0;
    #1;
    check("t6_psel", 32'(psel_a), 32'd0);
    check("t6_pen", 32'(pen_a), 32'd0);
    check("t6_pwrite", 32'(pwr_a), 32'd0);
    check("t6_paddr", paddr_a, 32'd0);
    check("t6_pwdata", pwdata_a, 32'd0);
    check("t6_err", 32'(err_a), 32'd0);
    run(2);
    reset_n = 1'b1; pready = 1'b1;
    run(8);
    check("t6_quiet", 32'(psel_a), 32'd0);
    exp_q.push_back({32'hE000_3000, 32'd1});
    ev = 4'b1000; tick(); ev = '0;
    run(10);

    check("dut_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sat_queue_empty", 32'(exp_sat_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_events_to_apb.md
MULTI_EVENTS_TO_APB -- requirements
Module: multi_events_to_apb

Interface
REQ-001 SHALL provide parameter NUM_EVENTS, default 4, number of event channels (legal range 2..16).
REQ-002 SHALL provide parameter CNT_W, default 8, per-channel event counter width (legal range 2..31).
REQ-003 SHALL provide parameter BASE_ADDR, default 32'hE000_0000, APB address of channel 0.
REQ-004 SHALL provide parameter ADDR_STRIDE, default 32'h0000_1000, address step per channel; channel k address = BASE_ADDR + k*ADDR_STRIDE, modulo 2^32.
REQ-005 SHALL provide ports: clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL provide: reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL provide: event_i  input  NUM_EVENTS  one-cycle event strobes, bit k = channel k.
REQ-008 SHALL provide: apb_psel_o, apb_penable_o, apb_pwrite_o  output  1 each  APB requester controls.
REQ-009 SHALL provide: apb_paddr_o, apb_pwdata_o  output  32 each  APB address and write data.
REQ-010 SHALL provide: apb_pready_i, apb_pslverr_i  input  1 each  APB completer response.
REQ-011 SHALL provide: apb_err_o  output  1  one-cycle pulse on an errored transfer.
REQ-012 SHALL provide: overflow_o  output  NUM_EVENTS  sticky per-channel saturation flag.

Function
REQ-013 SHALL keep one CNT_W-bit counter per channel; each cycle with event_i[k]=1, counter k increments by 1, saturating at 2^CNT_W-1.
REQ-014 SHALL set overflow_o[k] when an increment is lost to saturation; the flag holds until reset.
REQ-015 SHALL implement states IDLE, SETUP, ACCESS; illegal encodings return to IDLE.
REQ-016 IDLE: channel k is pending if counter k != 0 or event_i[k]=1; if any channel is pending, SHALL go to SETUP, else stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search begins at the channel after the last granted one (channel 0 after reset), wrapping at NUM_EVENTS-1.
REQ-018 On IDLE->SETUP, SHALL register paddr = address of the granted channel and pwdata = zero-extended saturating (counter + event_i bit); the granted counter is loaded with 0 in the same edge.
REQ-019 SETUP SHALL go to ACCESS unconditionally; ACCESS SHALL stay in ACCESS while apb_pready_i=0 and go to IDLE when apb_pready_i=1.
REQ-020 apb_psel_o=1 in SETUP and ACCESS; apb_penable_o=1 in ACCESS only; apb_pwrite_o=1 in SETUP and ACCESS.
REQ-021 apb_paddr_o and apb_pwdata_o SHALL hold stable through SETUP and ACCESS and read 0 in IDLE.
REQ-022 Events on the granted channel arriving during SETUP/ACCESS SHALL accumulate into its counter for a later transfer; none are lost except by saturation.
REQ-023 On ACCESS with apb_pready_i=1 and apb_pslverr_i=1, SHALL add the transferred value back into that channel's counter (saturating, together with any same-cycle event) and pulse apb_err_o for one cycle.
REQ-024 apb_pslverr_i SHALL be ignored when apb_pready_i=0 or outside ACCESS.
REQ-025 Latency: event in IDLE at cycle N -> psel at N+1, penable at N+2; minimum transfer 2 cycles plus 1 IDLE cycle between transfers.

Reset
REQ-026 While reset_n=0: state IDLE, all counters 0, overflow_o 0, round-robin pointer selects channel 0 first, all APB outputs 0, apb_err_o 0.
REQ-027 Reset asserted mid-transfer SHALL abort it immediately; the in-flight value and all pending counts are discarded.

Verification
REQ-028 Single event_i=4'b0010 pulse, pready=1 -> one transfer: paddr 32'hE000_1000, pwdata 1, psel at +1, penable at +2.
REQ-029 event_i=4'b1111 for one cycle, pready=1 -> four transfers, order ch0, ch1, ch2, ch3, each pwdata 1.
REQ-030 ch2 event held every cycle, pready held 0 for 5 ACCESS cycles -> paddr/pwdata stable; next ch2 transfer carries all accumulated events.
REQ-031 CNT_W=2, 5 ch0 events while bus stalled -> next ch0 pwdata 3, overflow_o[0]=1.
REQ-032 Transfer of value 3 completes with pslverr=1 -> apb_err_o pulses once; retry transfer carries 3 (plus new events).
REQ-033 reset_n low during ACCESS with counters nonzero -> outputs 0 at once; after release, no transfer until a new event.
